// File: rtl/vq_codebook_search.sv
// Nearest-codeword search: loads one feature vector serially, sweeps every codeword
// through the codebook ROM, accumulates squared Euclidean distance and reports the
// index/distance of the closest codeword. Ties keep the lower index.
module vq_codebook_search #(
  parameter int unsigned DATA_W  = 14,
  parameter int unsigned DIM     = 13,
  parameter int unsigned CW_NUM  = 16,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned ROM_LAT = 0,
  parameter int unsigned DIST_W  = 2 * (DATA_W + 1) + 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_idx,
  output logic [DIST_W-1:0] out_dist
);

  typedef enum logic [1:0] {StLoad, StSearch, StDone} state_e;

  localparam int unsigned ProdW = 2 * (DATA_W + 1);

  state_e              state_q, state_d;
  logic                in_ready_q, out_valid_q;
  logic [3:0]          load_cnt_q, cw_q, dim_q;
  logic                issuing_q, cmp_done_q;
  logic [DIST_W-1:0]   acc_q, best_dist_q, out_dist_q;
  logic [3:0]          best_idx_q, out_idx_q;
  logic [DATA_W-1:0]   feat_q [16];

  logic                accept, start, last_issue, iss_vld;
  logic                s_vld;
  logic [3:0]          s_cw, s_dim;
  logic signed [DATA_W:0]  diff;
  logic signed [ProdW-1:0] diff_x, prod;
  logic [DIST_W-1:0]   sq, cand;

  assign accept     = in_valid && in_ready_q && (state_q == StLoad);
  assign start      = accept && (load_cnt_q == 4'(DIM - 1));
  assign last_issue = (cw_q == 4'(CW_NUM - 1)) && (dim_q == 4'(DIM - 1));
  assign iss_vld    = (state_q == StSearch) && issuing_q;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_dist  = out_dist_q;
  assign rom_addr  = ADDR_W'({cw_q, dim_q});

  // Next-state decode for the load/search/done sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:   if (start) state_d = StSearch;
      StSearch: if (cmp_done_q) state_d = StDone;
      StDone:   if (out_ready) state_d = StLoad;
      default:  state_d = StLoad;
    endcase
  end

  // State plus registered handshake flags and the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StLoad;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_dist_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == StLoad);
      out_valid_q <= (state_d == StDone);
      if (state_q == StSearch && state_d == StDone) begin
        out_idx_q  <= best_idx_q;
        out_dist_q <= best_dist_q;
      end
    end
  end

  // Load counter and ROM address sweep; the address holds after the last issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt_q <= '0;
      cw_q       <= '0;
      dim_q      <= '0;
      issuing_q  <= 1'b0;
    end else if (start) begin
      load_cnt_q <= '0;
      cw_q       <= '0;
      dim_q      <= '0;
      issuing_q  <= 1'b1;
    end else begin
      if (accept) load_cnt_q <= load_cnt_q + 4'd1;
      if (iss_vld) begin
        if (last_issue) begin
          issuing_q <= 1'b0;
        end else if (dim_q == 4'(DIM - 1)) begin
          dim_q <= '0;
          cw_q  <= cw_q + 4'd1;
        end else begin
          dim_q <= dim_q + 4'd1;
        end
      end
    end
  end

  // Feature store; stale entries are simply overwritten by the next vector.
  always_ff @(posedge clk) begin
    if (accept) feat_q[load_cnt_q] <= in_data;
  end

  // Tags (valid/cw/dim) delayed to line up with the ROM read data.
  if (ROM_LAT == 0) begin : g_nolat
    assign s_vld = iss_vld;
    assign s_cw  = cw_q;
    assign s_dim = dim_q;
  end else begin : g_lat
    logic [ROM_LAT-1:0] vld_pipe;
    logic [3:0]         cw_pipe  [ROM_LAT];
    logic [3:0]         dim_pipe [ROM_LAT];

    // Tag shift register, ROM_LAT stages deep.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_pipe <= '0;
        for (int i = 0; i < ROM_LAT; i++) begin
          cw_pipe[i]  <= '0;
          dim_pipe[i] <= '0;
        end
      end else begin
        vld_pipe[0] <= iss_vld;
        cw_pipe[0]  <= cw_q;
        dim_pipe[0] <= dim_q;
        for (int i = 1; i < ROM_LAT; i++) begin
          vld_pipe[i] <= vld_pipe[i-1];
          cw_pipe[i]  <= cw_pipe[i-1];
          dim_pipe[i] <= dim_pipe[i-1];
        end
      end
    end

    assign s_vld = vld_pipe[ROM_LAT-1];
    assign s_cw  = cw_pipe[ROM_LAT-1];
    assign s_dim = dim_pipe[ROM_LAT-1];
  end

  // Difference is one bit wider than the operands so it never overflows.
  assign diff   = $signed({feat_q[s_dim][DATA_W-1], feat_q[s_dim]})
                - $signed({rom_data[DATA_W-1], rom_data});
  assign diff_x = {{(DATA_W + 1){diff[DATA_W]}}, diff};
  assign prod   = diff_x * diff_x;
  assign sq     = {{(DIST_W - ProdW){1'b0}}, prod};
  assign cand   = acc_q + sq;

  // Distance accumulation and strict-less-than best tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      best_dist_q <= '1;
      best_idx_q  <= '0;
      cmp_done_q  <= 1'b0;
    end else if (start) begin
      acc_q       <= '0;
      best_dist_q <= '1;
      best_idx_q  <= '0;
      cmp_done_q  <= 1'b0;
    end else if (s_vld) begin
      if (s_dim == 4'(DIM - 1)) begin
        acc_q <= '0;
        if (cand < best_dist_q) begin
          best_dist_q <= cand;
          best_idx_q  <= s_cw;
        end
        if (s_cw == 4'(CW_NUM - 1)) cmp_done_q <= 1'b1;
      end else begin
        acc_q <= cand;
      end
    end
  end

endmodule

// File: tb/tb_vq_codebook_search.sv
// Directed bench: one DUT with a combinational ROM, one with a registered ROM,
// both fed the same vectors and checked against hand-computed / modelled results.
module tb_vq_codebook_search;

  logic        clk = 1'b0;
  logic        rst_n, in_valid;
  logic [13:0] in_data;
  logic        in_ready0, in_ready1, out_valid0, out_valid1, out_ready0, out_ready1;
  logic [7:0]  rom_addr0, rom_addr1;
  logic [13:0] rom_data0, rom_data1;
  logic [3:0]  out_idx0, out_idx1;
  logic [33:0] out_dist0, out_dist1;

  logic signed [13:0] rom [16][16];
  logic signed [13:0] feat_v [13];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vq_codebook_search #(.ROM_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .rom_addr(rom_addr0), .rom_data(rom_data0), .out_valid(out_valid0),
    .out_ready(out_ready0), .out_idx(out_idx0), .out_dist(out_dist0)
  );

  vq_codebook_search #(.ROM_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_idx(out_idx1), .out_dist(out_dist1)
  );

  assign rom_data0 = rom[rom_addr0[7:4]][rom_addr0[3:0]];
  always @(posedge clk) rom_data1 <= rom[rom_addr1[7:4]][rom_addr1[3:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic void golden(output logic [3:0] gi, output logic [33:0] gd);
    longint s, best, df;
    best = 64'h3_FFFF_FFFF;
    gi = '0;
    for (int c = 0; c < 16; c++) begin
      s = 0;
      for (int d = 0; d < 13; d++) begin
        df = longint'(feat_v[d]) - longint'(rom[c][d]);
        s += df * df;
      end
      if (s < best) begin
        best = s;
        gi = 4'(c);
      end
    end
    gd = 34'(best);
  endfunction

  task automatic base_rom();
    for (int c = 0; c < 16; c++)
      for (int d = 0; d < 16; d++)
        rom[c][d] = (d < 13) ? 14'(c * 100 + d * 7 - 600) : 14'd0;
  endtask

  // Feed feat_v, then wait for both results (left pending, out_ready low).
  task automatic run_vec(input string tag, input logic [3:0] ei, input logic [33:0] ed);
    int w, n, lat0, lat1;
    logic [3:0]  i0, i1;
    logic [33:0] d0, d1;
    w = 0;
    while (!(in_ready0 && in_ready1) && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({tag, ":rdy"}, {in_ready0, in_ready1}, 2'b11);
    for (int k = 0; k < 13; k++) begin
      in_valid = 1'b1;
      in_data  = feat_v[k];
      @(negedge clk);
    end
    in_valid = 1'b0;
    n = 0; lat0 = 0; lat1 = 0; i0 = '0; i1 = '0; d0 = '0; d1 = '0;
    while ((lat0 == 0 || lat1 == 0) && n < 400) begin
      @(negedge clk);
      n++;
      if (out_valid0 && lat0 == 0) begin lat0 = n; i0 = out_idx0; d0 = out_dist0; end
      if (out_valid1 && lat1 == 0) begin lat1 = n; i1 = out_idx1; d1 = out_dist1; end
    end
    chk({tag, ":lat0"}, lat0, 209);
    chk({tag, ":idx0"}, i0, ei);
    chk({tag, ":dist0"}, d0, ed);
    chk({tag, ":lat1"}, lat1, 210);
    chk({tag, ":idx1"}, i1, ei);
    chk({tag, ":dist1"}, d1, ed);
  endtask

  task automatic release_out(input string tag);
    out_ready0 = 1'b1;
    out_ready1 = 1'b1;
    @(negedge clk);
    chk({tag, ":handoff"}, {out_valid0, in_ready0, out_valid1, in_ready1}, 4'b0101);
    out_ready0 = 1'b0;
    out_ready1 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  gi;
    logic [33:0] gd;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready0 = 1'b0; out_ready1 = 1'b0;
    base_rom();
    repeat (3) @(negedge clk);
    chk("rst0", {in_ready0, out_valid0, out_idx0, out_dist0, rom_addr0}, 64'd0);
    chk("rst1", {in_ready1, out_valid1, out_idx1, out_dist1, rom_addr1}, 64'd0);
    rst_n = 1'b1;
    #1 chk("rdy_before_edge", {in_ready0, in_ready1}, 2'b00);
    @(negedge clk);
    chk("rdy_after_edge", {in_ready0, in_ready1}, 2'b11);

    // Exact match with codeword 5.
    for (int d = 0; d < 13; d++) feat_v[d] = rom[5][d];
    run_vec("exact5", 4'd5, 34'd0);
    release_out("exact5");

    // Codewords 3 and 9 both at distance 13; the rest farther.
    for (int d = 0; d < 13; d++) begin
      feat_v[d] = 14'(d * 10);
      for (int c = 0; c < 16; c++) rom[c][d] = 14'(d * 10 + c + 2);
      rom[3][d] = 14'(d * 10 + 1);
      rom[9][d] = 14'(d * 10 - 1);
    end
    run_vec("tie", 4'd3, 34'd13);

    // Back-pressure: result held, nothing accepted while in_valid stays high.
    in_valid = 1'b1;
    in_data  = 14'h2000;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      chk("stall", {out_valid0, in_ready0, out_idx0, out_dist0, out_valid1, in_ready1, out_idx1},
          {1'b1, 1'b0, 4'd3, 34'd13, 1'b1, 1'b0, 4'd3});
    end
    in_valid = 1'b0;
    release_out("stall");

    // Extreme operands: every codeword at the full-scale opposite corner.
    for (int d = 0; d < 13; d++) begin
      feat_v[d] = 14'sd8191;
      for (int c = 0; c < 16; c++) rom[c][d] = -14'sd8192;
    end
    run_vec("extreme", 4'd0, 34'd3489234957);
    release_out("extreme");

    // Reset 100 cycles into a search, then a clean vector.
    base_rom();
    for (int d = 0; d < 13; d++) feat_v[d] = rom[5][d];
    for (int k = 0; k < 13; k++) begin
      in_valid = 1'b1;
      in_data  = feat_v[k];
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst0", {in_ready0, out_valid0, out_idx0, out_dist0, rom_addr0}, 64'd0);
    chk("midrst1", {in_ready1, out_valid1, out_idx1, out_dist1, rom_addr1}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 13; d++) feat_v[d] = rom[11][d];
    run_vec("post_rst", 4'd11, 34'd0);
    release_out("post_rst");

    // Random codebooks and features against the reference model.
    for (int t = 0; t < 4; t++) begin
      for (int c = 0; c < 16; c++)
        for (int d = 0; d < 13; d++) rom[c][d] = 14'($urandom_range(0, 16383));
      for (int d = 0; d < 13; d++) feat_v[d] = 14'($urandom_range(0, 16383));
      golden(gi, gd);
      run_vec("random", gi, gd);
      release_out("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
